data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 32: number of 32-bit words in the backing array (power of two, 4..1024).
REQ-002 The block SHALL have parameter LATENCY, default 3: number of cycles from request acceptance to ack (legal range 1..15).
REQ-003 The block SHALL have clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have req_i, input, 1 bit: memory request from the CPU MEM stage (MemRead or MemWrite).
REQ-006 The block SHALL have we_i, input, 1 bit: 1 = write, 0 = read; sampled at acceptance.
REQ-007 The block SHALL have addr_i, input, 32 bits: byte address; sampled at acceptance.
REQ-008 The block SHALL have wdata_i, input, 32 bits: write data; sampled at acceptance.
REQ-009 The block SHALL have rdata_o, output, 32 bits: read data; valid only in the ack_o cycle.
REQ-010 The block SHALL have ack_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have err_o, output, 1 bit: error flag; valid only with ack_o.
REQ-012 The block SHALL have stall_o, output, 1 bit: freezes the CPU pipeline (PC, IF/ID, ID/EX, EX/MEM) while a request is outstanding.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and DONE.
REQ-014 In IDLE with req_i=1, the block SHALL latch we_i/addr_i/wdata_i, load a 4-bit counter with LATENCY-1, and go to WAIT; if LATENCY=1, it SHALL go directly to DONE.
REQ-015 In WAIT, the counter SHALL decrement each cycle; the block SHALL go to DONE on the cycle the counter reads 1.
REQ-016 In DONE, ack_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-017 ack_o SHALL assert exactly LATENCY cycles after the acceptance edge.
REQ-018 stall_o SHALL be combinational: 1 when (state=IDLE and req_i=1) or state=WAIT; 0 in DONE, so the pipeline advances in the ack cycle.
REQ-019 req_i, we_i, addr_i and wdata_i SHALL be ignored in WAIT and DONE; changes to them SHALL NOT affect the in-flight request.
REQ-020 req_i=1 in IDLE on the cycle after DONE SHALL be accepted as a new request, giving back-to-back operation with one idle gap.
REQ-021 Word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2].
REQ-022 An error SHALL be flagged when latched addr[1:0]!=0 or addr >= 4*DEPTH_WORDS; in that case err_o=1 with ack_o, rdata_o=0, and no array write.
REQ-023 A valid write SHALL update the array on the DONE edge; rdata_o SHALL be 0 for writes.
REQ-024 A valid read SHALL drive array[index] on rdata_o in DONE, including the result of a write completed in the immediately preceding transaction.
REQ-025 Outside DONE, rdata_o, ack_o and err_o SHALL be 0.

Reset
REQ-026 While rst_n_i=0, the block SHALL be in state IDLE with counter=0, ack_o=0, err_o=0, rdata_o=0 and stall_o forced to 0.
REQ-027 Reset during WAIT or DONE SHALL abort the request without writing the array and without producing an ack.
REQ-028 Array contents SHALL be unaffected by reset.

Configuration
REQ-029 With DMEM_STATS_EN defined, the block SHALL add outputs rd_count_o[15:0] and wr_count_o[15:0], each incremented on every non-error read or write ack, saturating at 0xFFFF, and reset to 0.
REQ-030 Without DMEM_STATS_EN, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 LATENCY=3: write addr 0x8, data 0xDEADBEEF, req held → stall_o=1 for 3 cycles, ack_o in the 3rd cycle after acceptance, err_o=0.
REQ-032 Subsequent read of addr 0x8 issued the cycle after ack → ack_o 3 cycles later with rdata_o=0xDEADBEEF.
REQ-033 Read of addr 0x6 (misaligned) and of addr 0x80 with DEPTH_WORDS=32 → ack_o with err_o=1 and rdata_o=0; a later read of 0x0 shows its prior value unchanged.
REQ-034 LATENCY=1: 4 back-to-back reads → ack_o every second cycle, stall_o=1 only in the acceptance cycles.
REQ-035 Write 0x12345678 to 0x4, rst_n_i pulsed low during WAIT → no ack, stall_o=0, and a later read of 0x4 returns the old value.
REQ-036 With DMEM_STATS_EN: 3 reads, 2 writes, 1 error → rd_count_o=3, wr_count_o=2; after reset both counters are 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data-memory model for a pipelined CPU MEM stage. A request
//   is accepted in IDLE, held for LATENCY cycles, then completed with a
//   one-cycle ack_o carrying read data and an error flag. stall_o freezes
//   the CPU pipeline while the request is outstanding.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the backing array (power of 2, 4..1024)
//   LATENCY     : cycles from the acceptance edge to ack_o (1..15)
//
// Ports
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset (array contents preserved)
//   req_i      : memory request (MemRead or MemWrite)
//   we_i       : 1 = write, 0 = read; sampled at acceptance
//   addr_i     : byte address; sampled at acceptance
//   wdata_i    : write data; sampled at acceptance
//   rdata_o    : read data, valid only with ack_o (0 for writes and errors)
//   ack_o      : one-cycle completion pulse
//   err_o      : misaligned or out-of-range access, valid only with ack_o
//   stall_o    : pipeline freeze, combinational
//
// Optional feature (macro DMEM_STATS_EN)
//   rd_count_o : saturating count of non-error read completions
//   wr_count_o : saturating count of non-error write completions

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            bad_q, bad_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            enter_done;
    logic            mem_we;

    logic [31:0]     mem_q [DEPTH_WORDS];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        bad_d      = bad_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        enter_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    idx_d   = addr_i[AW+1:2];
                    wdata_d = wdata_i;
                    bad_d   = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered on entry to DONE; the *_d copies already
        // hold the request being completed (fresh inputs when LATENCY=1).
        if (enter_done) begin
            ack_d = 1'b1;
            err_d = bad_d;
            if (!bad_d && !we_d) begin
                rdata_d = mem_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array write happens on the edge leaving DONE; gated by reset so an
    // aborted request never lands in the array.
    assign mem_we = rst_n_i && (state_q == DONE) && we_q && !bad_q;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign stall_o = rst_n_i && (((state_q == IDLE) && req_i) || (state_q == WAIT));
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if ((state_q == DONE) && !bad_q) begin
            if (we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=3 and
// one with LATENCY=1, both DEPTH_WORDS=32.

module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ack, err, stall;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1;
    logic        ack1, err1, stall1;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack),
        .err_o(err), .stall_o(stall)
`ifdef DMEM_STATS_EN
        , .rd_count_o(rd_cnt), .wr_count_o(wr_cnt)
`endif
    );

    data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .we_i(we1),
        .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1),
        .err_o(err1), .stall_o(stall1)
`ifdef DMEM_STATS_EN
        , .rd_count_o(rd_cnt1), .wr_count_o(wr_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the LATENCY=3 instance. req is held until the ack;
    // while waiting, the request inputs are scrambled to show they are ignored.
    // ack_at is the negedge sample index of the ack (-1 if it never came).
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, output int ack_at,
                           output int stalls, output logic o_err,
                           output logic [31:0] o_rdata, output logic ack_after);
        @(posedge clk); #1;
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        ack_at = -1; stalls = 0; o_err = 1'bx; o_rdata = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (ack) begin
                ack_at  = k;
                o_err   = err;
                o_rdata = rdata;
                break;
            end
            if (k >= 1) begin
                we    = ~we;
                addr  = addr ^ 32'h0000_0081;
                wdata = ~wdata;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        ack_after = ack;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(negedge clk); @(negedge clk);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", ack); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL rst_stall1: got %b want 0", stall1); end
        tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL rst_ack1: got %b want 0", ack1); end
        req = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        int a, s; logic e, aa; logic [31:0] r;
        run_txn(1'b1, 32'h8, 32'hDEADBEEF, a, s, e, r, aa);
        tests++; if (a !== 3) begin fails++; $display("FAIL wr_ack_lat: got %0d want 3", a); end
        tests++; if (s !== 3) begin fails++; $display("FAIL wr_stall_cycles: got %0d want 3", s); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", e); end
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL wr_rdata: got %h want 0", r); end
        tests++; if (aa !== 1'b0) begin fails++; $display("FAIL wr_ack_pulse: got %b want 0", aa); end
        run_txn(1'b0, 32'h8, 32'h0, a, s, e, r, aa);
        tests++; if (a !== 3) begin fails++; $display("FAIL rd_ack_lat: got %0d want 3", a); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL rd_err: got %b want 0", e); end
        tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", r); end
        // last word of the array
        run_txn(1'b1, 32'h7C, 32'hA5A5_5A5A, a, s, e, r, aa);
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL wr_last_err: got %b want 0", e); end
        run_txn(1'b0, 32'h7C, 32'h0, a, s, e, r, aa);
        tests++; if (r !== 32'hA5A5_5A5A) begin fails++; $display("FAIL rd_last: got %h want a5a55a5a", r); end
    endtask

    task automatic test_errors;
        int a, s; logic e, aa; logic [31:0] r;
        run_txn(1'b1, 32'h0, 32'h0BADC0DE, a, s, e, r, aa);
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL wr0_err: got %b want 0", e); end
        run_txn(1'b0, 32'h6, 32'h0, a, s, e, r, aa);
        tests++; if (a !== 3) begin fails++; $display("FAIL mis_ack_lat: got %0d want 3", a); end
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL mis_err: got %b want 1", e); end
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL mis_rdata: got %h want 0", r); end
        run_txn(1'b0, 32'h80, 32'h0, a, s, e, r, aa);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_err: got %b want 1", e); end
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL oor_rdata: got %h want 0", r); end
        // erroring writes whose word index aliases onto word 0
        run_txn(1'b1, 32'h80, 32'hFFFF_FFFF, a, s, e, r, aa);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_wr_err: got %b want 1", e); end
        run_txn(1'b1, 32'h2, 32'h1111_1111, a, s, e, r, aa);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL mis_wr_err: got %b want 1", e); end
        run_txn(1'b0, 32'h0, 32'h0, a, s, e, r, aa);
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL rd0_err: got %b want 0", e); end
        tests++; if (r !== 32'h0BADC0DE) begin fails++; $display("FAIL rd0_unchanged: got %h want 0badc0de", r); end
    endtask

    task automatic test_back_to_back;
        logic exp_stall, exp_ack;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = '0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) addr1 = 32'(k * 2);
            @(negedge clk);
            exp_stall = (k % 2 == 0);
            exp_ack   = (k % 2 == 1);
            tests++; if (stall1 !== exp_stall) begin fails++; $display("FAIL b2b_stall[%0d]: got %b want %b", k, stall1, exp_stall); end
            tests++; if (ack1 !== exp_ack) begin fails++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack1, exp_ack); end
            if (k % 2 == 1) begin
                tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL b2b_err[%0d]: got %b want 0", k, err1); end
            end
            if (k < 7) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL b2b_end_stall: got %b want 0", stall1); end
        tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL b2b_end_ack: got %b want 0", ack1); end
    endtask

    task automatic test_reset_abort;
        int a, s, acks; logic e, aa; logic [31:0] r;
        run_txn(1'b1, 32'h4, 32'hCAFEF00D, a, s, e, r, aa);
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL ab_pre_err: got %b want 0", e); end
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h12345678;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ab_wait_stall: got %b want 1", stall); end
        rst_n = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ab_rst_stall: got %b want 0", stall); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL ab_rst_ack: got %b want 0", ack); end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL ab_no_ack: got %0d acks want 0", acks); end
        run_txn(1'b0, 32'h4, 32'h0, a, s, e, r, aa);
        tests++; if (r !== 32'hCAFEF00D) begin fails++; $display("FAIL ab_old_value: got %h want cafef00d", r); end
    endtask

    task automatic test_stats;
`ifdef DMEM_STATS_EN
        int a, s; logic e, aa; logic [31:0] r;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tests++; if (rd_cnt !== 16'd0) begin fails++; $display("FAIL st_rd0: got %0d want 0", rd_cnt); end
        tests++; if (wr_cnt !== 16'd0) begin fails++; $display("FAIL st_wr0: got %0d want 0", wr_cnt); end
        run_txn(1'b0, 32'h0,  32'h0, a, s, e, r, aa);
        run_txn(1'b1, 32'h10, 32'h1, a, s, e, r, aa);
        run_txn(1'b0, 32'h4,  32'h0, a, s, e, r, aa);
        run_txn(1'b0, 32'h6,  32'h0, a, s, e, r, aa);
        run_txn(1'b1, 32'h14, 32'h2, a, s, e, r, aa);
        run_txn(1'b0, 32'h8,  32'h0, a, s, e, r, aa);
        tests++; if (rd_cnt !== 16'd3) begin fails++; $display("FAIL st_rd: got %0d want 3", rd_cnt); end
        tests++; if (wr_cnt !== 16'd2) begin fails++; $display("FAIL st_wr: got %0d want 2", wr_cnt); end
        tests++; if (rd_cnt1 !== 16'd0) begin fails++; $display("FAIL st_rd_idle: got %0d want 0", rd_cnt1); end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        tests++; if (rd_cnt !== 16'd0) begin fails++; $display("FAIL st_rd_rst: got %0d want 0", rd_cnt); end
        tests++; if (wr_cnt !== 16'd0) begin fails++; $display("FAIL st_wr_rst: got %0d want 0", wr_cnt); end
        rst_n = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
